// File: rtl/haar_dwt_stream.sv
// One-level 1-D Haar wavelet over a streamed line of pixels: each sample pair
// (a,b) yields an LF beat (floor average) followed by an HF beat (offset-binary half difference).
module haar_dwt_stream #(
  parameter int IB     = 8,
  parameter int LINE_W = 640
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [IB-1:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [IB-1:0] m_data,
  output logic          m_region,
  output logic          m_last
);

  localparam int CW = $clog2(LINE_W + 1);
  localparam logic [IB-1:0] HALF = {1'b1, {(IB-1){1'b0}}};

  typedef enum logic [1:0] {S_A, S_B, S_LF, S_HF} state_t;

  state_t               state, state_next;
  logic [IB-1:0]        a_q, l_q, h_q;
  logic                 pair_last_q;
  logic [CW-1:0]        count;
  logic                 accept, line_end, take_a;
  logic [IB:0]          sum, h_full;
  logic signed [IB:0]   diff;
  logic [IB-1:0]        l_pair, h_pair;

  assign accept   = s_valid && s_ready;
  assign line_end = s_last || (count == CW'(LINE_W - 1));
  assign take_a   = accept && ((state == S_A) || (state == S_HF));

  // Both operands widened to IB+1 bits so neither the sum nor the difference wraps.
  assign sum    = {1'b0, a_q} + {1'b0, s_data};
  assign diff   = $signed({1'b0, s_data}) - $signed({1'b0, a_q});
  assign h_full = $unsigned(diff >>> 1) + {1'b0, HALF};
  assign l_pair = IB'(sum >> 1);
  assign h_pair = IB'(h_full);

  always_ff @(posedge clock) begin
    if (reset) state <= S_A;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (enable) begin
      case (state)
        S_A:  if (accept) state_next = line_end ? S_LF : S_B;
        S_B:  if (accept) state_next = S_LF;
        S_LF: if (m_ready) state_next = S_HF;
        S_HF: begin
          if (m_ready) begin
            if (accept) state_next = line_end ? S_LF : S_B;
            else        state_next = S_A;
          end
        end
        default: state_next = S_A;
      endcase
    end
  end

  always_comb begin
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_region = 1'b0;
    m_last   = 1'b0;
    if (!reset) begin
      s_ready = enable && ((state == S_A) || (state == S_B) ||
                           ((state == S_HF) && m_ready));
      if (state == S_LF) begin
        m_valid = 1'b1;
        m_data  = l_q;
      end else if (state == S_HF) begin
        m_valid  = 1'b1;
        m_data   = h_q;
        m_region = 1'b1;
        m_last   = pair_last_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q         <= '0;
      l_q         <= '0;
      h_q         <= '0;
      pair_last_q <= 1'b0;
      count       <= '0;
    end else if (accept) begin
      if (take_a) begin
        a_q <= s_data;
        if (line_end) begin
          // Line ends on an a sample: mirror it, so b=a gives L=a and a zero HF.
          l_q         <= s_data;
          h_q         <= HALF;
          pair_last_q <= 1'b1;
          count       <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        l_q         <= l_pair;
        h_q         <= h_pair;
        pair_last_q <= line_end;
        count       <= line_end ? '0 : count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_haar_dwt_stream.sv
// Randomized stream bench for haar_dwt_stream with a queue-based line/pair model.
module tb_haar_dwt_stream;
  localparam int IB = 8;
  localparam int LW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [IB-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [IB-1:0] m_data;
  logic          m_region;
  logic          m_last;

  haar_dwt_stream #(.IB(IB), .LINE_W(LW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_region(m_region), .m_last(m_last)
  );

  always #5 clock = ~clock;

  typedef struct {
    int d;
    int r;
    int l;
  } beat_t;

  beat_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    rmode = 1;
  int    m_have_a = 0;
  int    m_a = 0;
  int    m_cnt = 0;
  logic  prev_reset = 1'b1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    tests++;
    if (obs != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: L is the floor average, H the floor half-difference plus midscale.
  function automatic void emit(input int a, input int b, input int fin);
    int d, hh;
    beat_t lo, hi;
    d  = b - a;
    hh = (d >= 0) ? d / 2 : -((1 - d) / 2);
    lo.d = (a + b) / 2;  lo.r = 0; lo.l = 0;
    hi.d = hh + 128;     hi.r = 1; hi.l = fin;
    exp_q.push_back(lo);
    exp_q.push_back(hi);
  endfunction

  function automatic void model_accept(input int x, input int last);
    int fin;
    m_cnt++;
    fin = (last != 0 || m_cnt == LW) ? 1 : 0;
    if (m_have_a == 0) begin
      if (fin != 0) emit(x, x, 1);
      else begin
        m_a = x;
        m_have_a = 1;
      end
    end else begin
      emit(m_a, x, fin);
      m_have_a = 0;
    end
    if (fin != 0) m_cnt = 0;
  endfunction

  always @(posedge clock) begin
    #1;
    case (rmode)
      1:       m_ready = 1'b1;
      2:       m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_s_ready", int'(s_ready), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_m_region", int'(m_region), 0);
      chk("rst_m_last", int'(m_last), 0);
      exp_q.delete();
      m_have_a = 0;
      m_cnt = 0;
    end else begin
      if (prev_reset) chk("post_rst_s_ready", int'(s_ready), int'(enable));
      if (m_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", int'(m_valid), 0);
        else begin
          chk("m_data", int'(m_data), exp_q[0].d);
          chk("m_region", int'(m_region), exp_q[0].r);
          chk("m_last", int'(m_last), exp_q[0].l);
          if (m_ready && enable) void'(exp_q.pop_front());
        end
      end
      if (s_valid && s_ready && enable) model_accept(int'(s_data), int'(s_last));
    end
    prev_reset = reset;
  end

  task automatic send(input int x, input int last);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = IB'(x);
    s_last  = last[0];
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clock);
      if (s_ready && enable) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", int'(ok), 1);
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !m_valid) done = 1'b1;
    end
    chk("drain_timeout", int'(done), 1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // (10,20): LF must appear the cycle after b is taken
    rmode = 1;
    send(10, 0);
    send(20, 1);
    @(negedge clock);
    chk("latency_m_valid", int'(m_valid), 1);
    chk("latency_lf", int'(m_data), 15);
    drain();

    send(200, 0); send(50, 0); send(255, 0); send(0, 1);
    send(0, 0); send(255, 1);
    send(4, 0); send(6, 0); send(9, 1);
    drain();

    // Backpressure during LF
    rmode = 2;
    send(30, 0);
    send(40, 0);
    repeat (5) begin
      @(negedge clock);
      chk("stall_s_ready", int'(s_ready), 0);
      chk("stall_m_valid", int'(m_valid), 1);
    end
    @(posedge clock);
    #1 rmode = 1;
    send(50, 0); send(60, 1);
    drain();

    // Six samples with no s_last: forced line end at LW samples
    for (int i = 0; i < 6; i++) send(i * 37, 0);
    send(99, 1);
    drain();

    // Reset after an a sample is taken discards it
    send(7, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    send(2, 0);
    send(4, 1);
    drain();

    // Random lines, random gaps, random backpressure, occasional enable drop
    rmode = 0;
    for (int ln = 0; ln < 60; ln++) begin
      int len, use_last;
      len = int'($urandom_range(1, 7));
      use_last = int'($urandom_range(0, 3)) != 0 ? 1 : 0;
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 2)) @(posedge clock);
        #1;
        if ($urandom_range(0, 9) == 0) begin
          enable = 1'b0;
          @(negedge clock);
          chk("disabled_s_ready", int'(s_ready), 0);
          repeat (2) @(posedge clock);
          #1 enable = 1'b1;
        end
        send(int'($urandom_range(0, 255)), (j == len - 1) ? use_last : 0);
      end
    end
    rmode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
